// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared helpers for the pipe_reg_chain slice
// Sizing function for the occupancy counter.
package pipe_pkg;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+data register of the pipeline chain
// Flush clears valid only; data is written only when a valid word is loaded.
module pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             load,
   input  logic             flush,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= src_valid;
         if (src_valid) begin
            data <= src_data;
         end
      end
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - DEPTH-stage valid/ready pipeline with freeze, flush and bubble collapse
// Top holds the ready chain and occupancy sum; stages are pipe_stage instances.
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 3,
   localparam int OW    = occ_width(DEPTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             En,
   input  logic             Flush,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] Data_In,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Data_Out,
   output logic [OW-1:0]    Occupancy
);

   generate
      if (DEPTH < 1) begin : g_bad_depth
         $error("pipe_reg_chain: DEPTH must be at least 1");
      end
   endgenerate

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] d [DEPTH];
   logic [OW-1:0]    occ_sum;

   // Unrolled form of ready[k] = !v[k] | ready[k+1] with ready[DEPTH] = Out_Ready:
   // a stage can take a word if the sink drains or any stage at or beyond it is empty.
   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_ready
         assign ready[k] = Out_Ready | ~(&v[DEPTH-1:k]);
         assign load[k]  = En & ready[k];
      end
   endgenerate

   generate
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         if (k == 0) begin : g_first
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .Clock     (Clock),
               .Reset     (Reset),
               .load      (load[k]),
               .flush     (Flush),
               .src_valid (In_Valid),
               .src_data  (Data_In),
               .valid     (v[k]),
               .data      (d[k])
            );
         end else begin : g_next
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .Clock     (Clock),
               .Reset     (Reset),
               .load      (load[k]),
               .flush     (Flush),
               .src_valid (v[k-1]),
               .src_data  (d[k-1]),
               .valid     (v[k]),
               .data      (d[k])
            );
         end
      end
   endgenerate

   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_sum = occ_sum + OW'(v[k]);
      end
   end

   // Reset gating keeps In_Ready low while reset is held, even though stage 0 is empty.
   assign In_Ready  = Reset & En & ~Flush & ready[0];
   assign Out_Valid = v[DEPTH-1];
   assign Data_Out  = d[DEPTH-1];
   assign Occupancy = occ_sum;

endmodule
